hud_game_ctrl: RTL and testbench

- Producer side of the HUD seven-segment interface. Owns the game state that the display shows: P1/P2 scores, current player, the per-turn countdown timer and the winner.
- Emits 4-bit digit codes that the HUD feeds directly into its seven-segment decoders. Codes 0–9 render as digits; any other code renders "P".
- Inputs come from the card-match logic: one pulse per completed flip pair, with a hit/miss flag.

---
 rtl/hud_game_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hud_game_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hud_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hud_game_ctrl
//  Purpose  : Game-state producer for the HUD seven-segment display. Tracks
//             P1/P2 scores, the current player, a per-turn BCD countdown and
//             the winner. Every output is a 4-bit digit code (0-9 = digit,
//             anything else renders "P") or a flag, and all are registered.
//  Ports    : clk        - system clock
//             reset      - synchronous active-high reset
//             start      - pulse, starts a game from IDLE or OVER
//             pair_valid - pulse, a two-card flip completed
//             pair_hit   - qualifies pair_valid (1 = match, 0 = miss)
//             p1_score   - P1 score digit          (HEX0)
//             p2_score   - P2 score digit          (HEX1)
//             timer_tens - countdown tens digit    (HEX3)
//             timer_ones - countdown ones digit    (HEX2)
//             cur_player - 4'h1 / 4'h2             (HEX4)
//             winner     - 1 / 2 / 0 tie, F unless game over (HEX6)
//             game_over  - high while in OVER
//  Revision : 1.0 - initial release
// ============================================================================
module hud_game_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int TURN_SECONDS = 15,
  parameter int TOTAL_PAIRS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pair_valid,
  input  logic       pair_hit,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] timer_tens,
  output logic [3:0] timer_ones,
  output logic [3:0] cur_player,
  output logic [3:0] winner,
  output logic       game_over
);

  localparam int                 c_DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]         c_TENS    = 4'(TURN_SECONDS / 10);
  localparam logic [3:0]         c_ONES    = 4'(TURN_SECONDS % 10);
  localparam logic [4:0]         c_TOTAL   = 5'(TOTAL_PAIRS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_DIV_W-1:0] r_div;
  logic [3:0]         r_p1;
  logic [3:0]         r_p2;
  logic [3:0]         r_cur;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic [3:0]         r_winner;
  logic               r_over;

  logic       w_tick;
  logic       w_timer_zero;
  logic [3:0] w_p1_inc;
  logic [3:0] w_p2_inc;
  logic [3:0] w_p1_hit;
  logic [3:0] w_p2_hit;
  logic [4:0] w_sum_hit;
  logic       w_done;
  logic [3:0] w_win_hit;
  logic [3:0] w_other;

  assign w_tick       = (r_state == S_PLAY) && (r_div == c_DIV_MAX);
  assign w_timer_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_other      = (r_cur == 4'h2) ? 4'h1 : 4'h2;

  // Scores saturate at 9 so the display never shows a non-digit code.
  assign w_p1_inc = (r_p1 >= 4'd9) ? 4'd9 : r_p1 + 4'd1;
  assign w_p2_inc = (r_p2 >= 4'd9) ? 4'd9 : r_p2 + 4'd1;

  // Scores as they would be after a hit by the current player; the game-end
  // decision and winner must include that final hit.
  always_comb begin
    w_p1_hit = r_p1;
    w_p2_hit = r_p2;
    if (r_cur == 4'h2) begin
      w_p2_hit = w_p2_inc;
    end else begin
      w_p1_hit = w_p1_inc;
    end
  end

  assign w_sum_hit = {1'b0, w_p1_hit} + {1'b0, w_p2_hit};
  assign w_done    = (w_sum_hit >= c_TOTAL);
  assign w_win_hit = (w_p1_hit > w_p2_hit) ? 4'h1 :
                     (w_p2_hit > w_p1_hit) ? 4'h2 : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_p1     <= 4'd0;
      r_p2     <= 4'd0;
      r_cur    <= 4'h1;
      r_tens   <= c_TENS;
      r_ones   <= c_ONES;
      r_winner <= 4'hF;
      r_over   <= 1'b0;
    end else if ((r_state == S_IDLE || r_state == S_OVER) && start) begin
      r_state  <= S_PLAY;
      r_div    <= '0;
      r_p1     <= 4'd0;
      r_p2     <= 4'd0;
      r_cur    <= 4'h1;
      r_tens   <= c_TENS;
      r_ones   <= c_ONES;
      r_winner <= 4'hF;
      r_over   <= 1'b0;
    end else if (r_state == S_PLAY) begin
      if (pair_valid) begin
        // A flip result takes priority over a coincident tick (tick dropped).
        r_div  <= '0;
        r_tens <= c_TENS;
        r_ones <= c_ONES;
        if (pair_hit) begin
          r_p1 <= w_p1_hit;
          r_p2 <= w_p2_hit;
          if (w_done) begin
            r_state  <= S_OVER;
            r_winner <= w_win_hit;
            r_over   <= 1'b1;
          end
        end else begin
          r_cur <= w_other;
        end
      end else if (w_tick) begin
        r_div <= '0;
        if (w_timer_zero) begin
          // 00 has been shown for a full second: hand the turn over.
          r_cur  <= w_other;
          r_tens <= c_TENS;
          r_ones <= c_ONES;
        end else if (r_ones == 4'd0) begin
          r_ones <= 4'd9;
          r_tens <= r_tens - 4'd1;
        end else begin
          r_ones <= r_ones - 4'd1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end else begin
      r_div <= '0;
    end
  end

  assign p1_score   = r_p1;
  assign p2_score   = r_p2;
  assign timer_tens = r_tens;
  assign timer_ones = r_ones;
  assign cur_player = r_cur;
  assign winner     = r_winner;
  assign game_over  = r_over;

endmodule
`default_nettype wire

// File: tb/tb_hud_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hud_game_ctrl
//  Purpose  : Self-checking bench for hud_game_ctrl. Directed stimulus pushes
//             hand-computed expected displays into a queue; a monitor on the
//             falling clock edge pops and compares them against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hud_game_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int TURN_SECONDS = 15;
  localparam int TOTAL_PAIRS  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pair_valid;
  logic       pair_hit;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] timer_tens;
  logic [3:0] timer_ones;
  logic [3:0] cur_player;
  logic [3:0] winner;
  logic       game_over;

  always #5 clk = ~clk;

  hud_game_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .TURN_SECONDS(TURN_SECONDS),
    .TOTAL_PAIRS (TOTAL_PAIRS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pair_valid(pair_valid),
    .pair_hit  (pair_hit),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .timer_tens(timer_tens),
    .timer_ones(timer_ones),
    .cur_player(cur_player),
    .winner    (winner),
    .game_over (game_over)
  );

  typedef struct {
    string      nm;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] cur;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] win;
    logic       over;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic cmp(input string nm, input string fld,
                     input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, required %h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are stable by the falling edge; check everything queued.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.nm, "p1_score",   p1_score,   e.p1);
      cmp(e.nm, "p2_score",   p2_score,   e.p2);
      cmp(e.nm, "cur_player", cur_player, e.cur);
      cmp(e.nm, "timer_tens", timer_tens, e.tens);
      cmp(e.nm, "timer_ones", timer_ones, e.ones);
      cmp(e.nm, "winner",     winner,     e.win);
      cmp(e.nm, "game_over",  {3'b000, game_over}, {3'b000, e.over});
    end
  end

  task automatic expect_o(input string nm, input logic [3:0] p1, input logic [3:0] p2,
                          input logic [3:0] cur, input logic [3:0] tens,
                          input logic [3:0] ones, input logic [3:0] win,
                          input logic over);
    exp_t e;
    e.nm = nm; e.p1 = p1; e.p2 = p2; e.cur = cur;
    e.tens = tens; e.ones = ones; e.win = win; e.over = over;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pair(input logic hit);
    pair_valid = 1'b1;
    pair_hit   = hit;
    step(1);
    pair_valid = 1'b0;
    pair_hit   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pair_valid = 1'b0; pair_hit = 1'b0;
    step(2);
    reset = 1'b0;
    step(10);
    expect_o("reset_idle", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);
    pair(1'b1);
    expect_o("idle_pair_ignored", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);

    // Countdown: one tick every TICK_DIV cycles after the start edge.
    pulse_start();
    expect_o("start", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);
    step(16);
    expect_o("tick4", 4'd0, 4'd0, 4'h1, 4'd1, 4'd1, 4'hF, 1'b0);
    step(4);
    expect_o("tick5", 4'd0, 4'd0, 4'h1, 4'd1, 4'd0, 4'hF, 1'b0);
    step(4);
    expect_o("tick6_borrow", 4'd0, 4'd0, 4'h1, 4'd0, 4'd9, 4'hF, 1'b0);
    step(36);
    expect_o("tick15_zero", 4'd0, 4'd0, 4'h1, 4'd0, 4'd0, 4'hF, 1'b0);
    step(3);
    expect_o("zero_held", 4'd0, 4'd0, 4'h1, 4'd0, 4'd0, 4'hF, 1'b0);
    step(1);
    expect_o("timeout", 4'd0, 4'd0, 4'h2, 4'd1, 4'd5, 4'hF, 1'b0);

    // Pair handling.
    pair(1'b0);
    expect_o("miss_p2", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);
    pair(1'b1);
    expect_o("hit_p1", 4'd1, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);
    pair(1'b0);
    expect_o("miss_p1", 4'd1, 4'd0, 4'h2, 4'd1, 4'd5, 4'hF, 1'b0);
    pair(1'b1);
    expect_o("hit_p2", 4'd1, 4'd1, 4'h2, 4'd1, 4'd5, 4'hF, 1'b0);
    step(3);
    pair(1'b1);  // lands on the tick edge
    expect_o("hit_on_tick", 4'd1, 4'd2, 4'h2, 4'd1, 4'd5, 4'hF, 1'b0);
    step(3);
    expect_o("div_cleared", 4'd1, 4'd2, 4'h2, 4'd1, 4'd5, 4'hF, 1'b0);
    step(1);
    expect_o("tick_after_hit", 4'd1, 4'd2, 4'h2, 4'd1, 4'd4, 4'hF, 1'b0);
    pulse_start();
    expect_o("start_in_play", 4'd1, 4'd2, 4'h2, 4'd1, 4'd4, 4'hF, 1'b0);
    start = 1'b1;
    pair(1'b0);
    start = 1'b0;
    expect_o("start_and_miss", 4'd1, 4'd2, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);

    // Game end, P1 wins 5-3.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    pulse_start();
    repeat (5) pair(1'b1);
    pair(1'b0);
    repeat (2) pair(1'b1);
    expect_o("before_end", 4'd5, 4'd2, 4'h2, 4'd1, 4'd5, 4'hF, 1'b0);
    pair(1'b1);
    expect_o("end_p1_wins", 4'd5, 4'd3, 4'h2, 4'd1, 4'd5, 4'h1, 1'b1);
    step(10);
    expect_o("over_frozen", 4'd5, 4'd3, 4'h2, 4'd1, 4'd5, 4'h1, 1'b1);
    pair(1'b1);
    pair(1'b0);
    expect_o("over_pair_ignored", 4'd5, 4'd3, 4'h2, 4'd1, 4'd5, 4'h1, 1'b1);
    pulse_start();
    expect_o("restart1", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);

    // Tie 4-4.
    repeat (4) pair(1'b1);
    pair(1'b0);
    repeat (4) pair(1'b1);
    expect_o("end_tie", 4'd4, 4'd4, 4'h2, 4'd1, 4'd5, 4'h0, 1'b1);
    pulse_start();
    expect_o("restart2", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);

    // Reset mid-second in PLAY.
    repeat (3) pair(1'b1);
    expect_o("p1_three", 4'd3, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_o("mid_reset", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);
    step(8);
    expect_o("no_ticks_idle", 4'd0, 4'd0, 4'h1, 4'd1, 4'd5, 4'hF, 1'b0);

    step(2);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
